// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared definitions for the booth multiplier arbiter and the
//               booth_multiplier it sequences. Holds the controller state
//               encoding and the default operand width and iteration latency.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Default operand width; the product is twice this wide.
    localparam int c_DEFAULT_N       = 32;
    // booth_multiplier retires one bit per enabled cycle, so latency == N.
    localparam int c_DEFAULT_LATENCY = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Grants the first asserted
//               request at or after the pointer, wrapping modulo NUM_REQ.
//               The pointer register lives in the parent.
// Ports       : req     - request vector
//               ptr     - highest-priority index this cycle
//               gnt     - one-hot grant (zero when no request)
//               gnt_idx - binary index of the granted request
//               any_gnt - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_gnt
);

    int w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        w_idx   = 0;
        // Scan from the farthest position back toward ptr so the request
        // nearest the pointer is the last (winning) assignment.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(ptr) + k) % NUM_REQ;
            if (req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
                gnt_idx    = ID_W'(w_idx);
                any_gnt    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_arbiter
// Description : Shares one external iterative booth_multiplier among NUM_REQ
//               requesters. Round-robin grants a request, loads its operands,
//               restarts the multiplier, runs it for LATENCY enabled cycles,
//               then presents the product with the requester ID on a single
//               valid/ready response channel.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               req_valid/ready/a/b    - per-requester request channels
//               resp_valid/ready/id/c  - shared response channel
//               mul_rst/en/a/b, mul_c  - multiplier control, operands, product
//               busy                   - controller is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_arbiter
    import booth_pkg::*;
#(
    parameter int N       = c_DEFAULT_N,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = c_DEFAULT_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [2*N-1:0]       resp_c,
    output logic                 mul_rst,
    output logic                 mul_en,
    output logic [N-1:0]         mul_a,
    output logic [N-1:0]         mul_b,
    input  logic [2*N-1:0]       mul_c,
    output logic                 busy
);

    localparam int                 c_CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LATENCY - 1);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_any_gnt;
    logic [N-1:0]       w_sel_a;
    logic [N-1:0]       w_sel_b;
    logic [ID_W-1:0]    w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any_gnt (w_any_gnt)
    );

    assign w_sel_a    = req_a[int'(w_gnt_idx)*N +: N];
    assign w_sel_b    = req_b[int'(w_gnt_idx)*N +: N];
    assign w_ptr_next = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + ID_W'(1);

    // Grant is visible in the same IDLE cycle; masked during reset so a
    // requester never believes it was accepted by an edge that reset wins.
    assign req_ready = (r_state == ST_IDLE && !rst) ? w_gnt : '0;
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_c     <= '0;
            mul_rst    <= 1'b1;
            mul_en     <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_gnt) begin
                        mul_a   <= w_sel_a;
                        mul_b   <= w_sel_b;
                        resp_id <= w_gnt_idx;
                        r_ptr   <= w_ptr_next;
                        mul_rst <= 1'b1;
                        mul_en  <= 1'b0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Multiplier sees restart for exactly this cycle.
                    r_cnt   <= '0;
                    mul_rst <= 1'b0;
                    mul_en  <= 1'b1;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (r_cnt == c_CNT_LAST) begin
                        resp_c     <= mul_c;
                        resp_valid <= 1'b1;
                        mul_en     <= 1'b0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult_arbiter
// Description : Self-checking bench for booth_mult_arbiter. Includes a
//               behavioural multiplier that presents the product only after
//               the restart plus enough enabled cycles, and garbage before.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_arbiter;

    localparam int N       = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int LATENCY = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [2*N-1:0]       resp_c;
    logic                 mul_rst;
    logic                 mul_en;
    logic [N-1:0]         mul_a;
    logic [N-1:0]         mul_b;
    logic [2*N-1:0]       mul_c;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int tb_ptr   = 0;

    always #5 clk = ~clk;

    booth_mult_arbiter #(
        .N (N), .NUM_REQ (NUM_REQ), .ID_W (ID_W), .LATENCY (LATENCY)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_a (req_a), .req_b (req_b),
        .resp_valid (resp_valid), .resp_ready (resp_ready),
        .resp_id (resp_id), .resp_c (resp_c),
        .mul_rst (mul_rst), .mul_en (mul_en),
        .mul_a (mul_a), .mul_b (mul_b), .mul_c (mul_c),
        .busy (busy)
    );

    // Behavioural multiplier: latches operands on restart, counts enabled
    // cycles, and drives the true product only once enough have elapsed.
    logic [N-1:0]          m_a, m_b;
    int                    m_cnt = 0;
    logic [2*N-1:0]        m_junk = '0;
    logic signed [2*N-1:0] m_ea, m_eb;

    always @(posedge clk) begin
        m_junk <= {$urandom, $urandom};
        if (mul_rst) begin
            m_cnt <= 0;
            m_a   <= mul_a;
            m_b   <= mul_b;
        end else if (mul_en) begin
            m_cnt <= m_cnt + 1;
        end
    end

    always_comb begin
        m_ea  = $signed(m_a);
        m_eb  = $signed(m_b);
        mul_c = (m_cnt >= LATENCY - 1) ? m_ea * m_eb : m_junk;
    end

    // Protocol monitor: grant one-hot or zero, never while busy; and track
    // whether requester 2 is ever granted while being watched.
    int proto_viol = 0;
    int r2_seen    = 0;
    bit r2_watch   = 0;
    always @(negedge clk) begin
        if (!rst && (!$onehot0(req_ready) || (req_ready != '0 && busy)))
            proto_viol <= proto_viol + 1;
        if (!rst && r2_watch && req_ready[2])
            r2_seen <= r2_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin: first valid index at/after the pointer.
    task automatic model_pick(input logic [NUM_REQ-1:0] mask, output int g);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (g < 0 && mask[(tb_ptr + k) % NUM_REQ]) g = (tb_ptr + k) % NUM_REQ;
        end
        if (g >= 0) tb_ptr = (g + 1) % NUM_REQ;
    endtask

    // Waits for a grant, computes the expected product from the operands the
    // bench drove for that requester, and steps over the accepting edge.
    task automatic grant_wait(output int g, output bit ok, output logic [2*N-1:0] expc);
        logic signed [N-1:0]   sa, sb;
        logic signed [2*N-1:0] ea, eb;
        ok = 0; g = -1; expc = '0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != '0) begin
                for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) g = j;
                sa = req_a[g*N +: N];
                sb = req_b[g*N +: N];
                ea = sa; eb = sb;
                expc = ea * eb;
                ok = 1;
                tick();
                return;
            end
            tick();
        end
    endtask

    // Counts cycles from the LOAD cycle until resp_valid is seen.
    task automatic resp_wait(output int lat, output logic [2*N-1:0] c, output int id, output bit ok);
        ok = 0; lat = -1; c = '0; id = -1;
        for (int i = 0; i < 200; i++) begin
            if (resp_valid === 1'b1) begin
                lat = i; c = resp_c; id = int'(resp_id); ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1; req_valid = '1; resp_ready = 1;
        for (int i = 0; i < NUM_REQ; i++) begin req_a[i*N +: N] = $urandom; req_b[i*N +: N] = $urandom; end
        tick(); tick(); #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%h want=0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL reset_resp_id got=%0d want=0", resp_id); end
        checks++; if (resp_c !== 64'd0) begin failures++; $display("FAIL reset_resp_c got=%h want=0", resp_c); end
        checks++; if ({mul_rst, mul_en} !== 2'b10) begin failures++; $display("FAIL reset_mul_ctl got=%b want=10", {mul_rst, mul_en}); end
        checks++; if ({mul_a, mul_b} !== 64'd0) begin failures++; $display("FAIL reset_mul_ops got=%h want=0", {mul_a, mul_b}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        req_valid = '0;
        rst = 0; tb_ptr = 0;
        tick();
    endtask

    task automatic test_directed();
        logic signed [N-1:0] ta [6];
        logic signed [N-1:0] tbv [6];
        logic [2*N-1:0]      te [6];
        int g, eg, lat, id; bit ok; logic [2*N-1:0] expc, c;
        ta  = '{32'sd5, 32'sd12, -32'sd12, 32'sd0, 32'sh8000_0000, 32'sh7FFF_FFFF};
        tbv = '{32'sd10, -32'sd3, -32'sd12, 32'sd10, 32'sh8000_0000, -32'sd1};
        te  = '{64'd50, 64'hFFFF_FFFF_FFFF_FFDC, 64'd144, 64'd0,
                64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0001};
        resp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            req_a[0 +: N] = ta[i]; req_b[0 +: N] = tbv[i]; req_valid = 4'b0001;
            model_pick(req_valid, eg);
            grant_wait(g, ok, expc);
            checks++; if (!ok || g != eg) begin failures++; $display("FAIL dir_grant[%0d] got=%0d want=%0d", i, g, eg); end
            #1;
            checks++; if (req_ready !== 4'b0 || {mul_rst, mul_en} !== 2'b10) begin failures++; $display("FAIL dir_load[%0d] got=ready %h ctl %b want=ready 0 ctl 10", i, req_ready, {mul_rst, mul_en}); end
            req_valid = '0;
            resp_wait(lat, c, id, ok);
            checks++; if (!ok || lat != LATENCY + 1) begin failures++; $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, LATENCY + 1); end
            checks++; if (c !== te[i]) begin failures++; $display("FAIL dir_product[%0d] got=%h want=%h", i, c, te[i]); end
            checks++; if (id != 0 || {mul_a, mul_b} !== {ta[i], tbv[i]}) begin failures++; $display("FAIL dir_id_ops[%0d] got=id %0d ops %h want=id 0 ops %h", i, id, {mul_a, mul_b}, {ta[i], tbv[i]}); end
            tick();
        end
    endtask

    task automatic test_contention();
        int ord [5];
        int g, eg, lat, id; bit ok; logic [2*N-1:0] expc, c;
        ord = '{0, 1, 2, 3, 0};
        rst = 1; req_valid = '1; resp_ready = 1;
        for (int i = 0; i < NUM_REQ; i++) begin req_a[i*N +: N] = $urandom; req_b[i*N +: N] = $urandom; end
        tick();
        rst = 0; tb_ptr = 0;
        for (int j = 0; j < 5; j++) begin
            model_pick(req_valid, eg);
            grant_wait(g, ok, expc);
            checks++; if (!ok || g != ord[j] || g != eg) begin failures++; $display("FAIL cont_grant[%0d] got=%0d want=%0d", j, g, ord[j]); end
            if (j == 0) begin
                req_a[0 +: N] = $urandom; req_b[0 +: N] = $urandom;   // requester 0 re-requests
            end else if (g >= 0) begin
                req_valid[g] = 1'b0;
            end
            resp_wait(lat, c, id, ok);
            checks++; if (!ok || c !== expc || id != g) begin failures++; $display("FAIL cont_resp[%0d] got=id %0d c %h want=id %0d c %h", j, id, c, g, expc); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int r, g, eg, lat, id, changed; bit ok; logic [2*N-1:0] expc, c;
        r = $urandom_range(0, NUM_REQ - 1);
        req_a[r*N +: N] = $urandom; req_b[r*N +: N] = $urandom;
        resp_ready = 0; req_valid = '0; req_valid[r] = 1'b1;
        model_pick(req_valid, eg);
        grant_wait(g, ok, expc);
        checks++; if (!ok || g != eg) begin failures++; $display("FAIL bp_grant got=%0d want=%0d", g, eg); end
        req_valid = '0;
        resp_wait(lat, c, id, ok);
        checks++; if (!ok || c !== expc || id != r) begin failures++; $display("FAIL bp_resp got=id %0d c %h want=id %0d c %h", id, c, r, expc); end
        req_valid[(r + 1) % NUM_REQ] = 1'b1;
        changed = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            if (resp_valid !== 1'b1 || resp_c !== c || int'(resp_id) != id || req_ready !== 4'b0) changed++;
        end
        checks++; if (changed != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d bad cycles want=0", changed); end
        resp_ready = 1;
        tick();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b want=0", resp_valid); end
        model_pick(req_valid, eg);
        grant_wait(g, ok, expc);
        checks++; if (!ok || g != eg) begin failures++; $display("FAIL bp_next_grant got=%0d want=%0d", g, eg); end
        req_valid = '0;
        resp_wait(lat, c, id, ok);
        checks++; if (!ok || c !== expc || id != eg) begin failures++; $display("FAIL bp_next_resp got=id %0d c %h want=id %0d c %h", id, c, eg, expc); end
        tick();
    endtask

    task automatic test_reset_midrun();
        int g, eg, lat, id, seen; bit ok; logic [2*N-1:0] expc, c;
        resp_ready = 1;
        req_a[2*N +: N] = $urandom; req_b[2*N +: N] = $urandom; req_valid = 4'b0100;
        model_pick(req_valid, eg);
        grant_wait(g, ok, expc);
        req_valid = '0;
        tick();
        repeat (10) tick();
        checks++; if (!ok || g != 2 || mul_en !== 1'b1) begin failures++; $display("FAIL mid_running got=grant %0d en %b want=grant 2 en 1", g, mul_en); end
        rst = 1;
        tick();
        checks++; if (resp_valid !== 1'b0 || resp_c !== 64'd0 || resp_id !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset_resp got=v %b c %h id %0d busy %b want=all 0", resp_valid, resp_c, resp_id, busy); end
        checks++; if ({mul_rst, mul_en} !== 2'b10 || {mul_a, mul_b} !== 64'd0) begin failures++; $display("FAIL mid_reset_mul got=ctl %b ops %h want=ctl 10 ops 0", {mul_rst, mul_en}, {mul_a, mul_b}); end
        rst = 0; tb_ptr = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (resp_valid !== 1'b0) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_no_resp got=%0d want=0", seen); end
        for (int i = 0; i < NUM_REQ; i++) begin req_a[i*N +: N] = $urandom; req_b[i*N +: N] = $urandom; end
        req_valid = '1;
        model_pick(req_valid, eg);
        grant_wait(g, ok, expc);
        checks++; if (!ok || g != 0 || g != eg) begin failures++; $display("FAIL mid_ptr_cleared got=%0d want=0", g); end
        req_valid = '0;
        resp_wait(lat, c, id, ok);
        checks++; if (!ok || c !== expc || id != 0 || lat != LATENCY + 1) begin failures++; $display("FAIL mid_fresh_resp got=id %0d c %h lat %0d want=id 0 c %h lat %0d", id, c, lat, expc, LATENCY + 1); end
        tick();
    endtask

    task automatic test_retract();
        int g, eg, lat, id; bit ok; logic [2*N-1:0] expc, c;
        resp_ready = 1;
        for (int i = 0; i < NUM_REQ; i++) begin req_a[i*N +: N] = $urandom; req_b[i*N +: N] = $urandom; end
        req_valid = 4'b0010;
        model_pick(req_valid, eg);
        grant_wait(g, ok, expc);
        checks++; if (!ok || g != 1) begin failures++; $display("FAIL retract_first got=%0d want=1", g); end
        r2_watch = 1;
        req_valid = 4'b0100;
        repeat (5) tick();
        req_valid = 4'b1000;
        resp_wait(lat, c, id, ok);
        checks++; if (!ok || c !== expc) begin failures++; $display("FAIL retract_first_resp got=%h want=%h", c, expc); end
        tick();
        model_pick(req_valid, eg);
        grant_wait(g, ok, expc);
        checks++; if (!ok || g != 3 || g != eg) begin failures++; $display("FAIL retract_next got=%0d want=3", g); end
        req_valid = '0;
        resp_wait(lat, c, id, ok);
        checks++; if (!ok || c !== expc || id != 3) begin failures++; $display("FAIL retract_next_resp got=id %0d c %h want=id 3 c %h", id, c, expc); end
        tick();
        r2_watch = 0;
        checks++; if (r2_seen != 0) begin failures++; $display("FAIL retract_r2_granted got=%0d want=0", r2_seen); end
    endtask

    task automatic test_random();
        int g, eg, lat, id; bit ok; logic [2*N-1:0] expc, c;
        resp_ready = 1;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin req_a[i*N +: N] = $urandom; req_b[i*N +: N] = $urandom; end
            req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            model_pick(req_valid, eg);
            grant_wait(g, ok, expc);
            checks++; if (!ok || g != eg) begin failures++; $display("FAIL rand_grant[%0d] got=%0d want=%0d", j, g, eg); end
            req_valid = '0;
            resp_wait(lat, c, id, ok);
            checks++; if (!ok || c !== expc || id != eg || lat != LATENCY + 1) begin failures++; $display("FAIL rand_resp[%0d] got=id %0d c %h lat %0d want=id %0d c %h lat %0d", j, id, c, lat, eg, expc, LATENCY + 1); end
            tick();
        end
    endtask

    task automatic test_protocol();
        checks++; if (proto_viol != 0) begin failures++; $display("FAIL protocol_grant got=%0d violations want=0", proto_viol); end
    endtask

    initial begin
        rst = 1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1;
        test_reset();
        test_directed();
        test_contention();
        test_backpressure();
        test_reset_midrun();
        test_retract();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
